// File: rtl/apu_clk_div_if.sv
// Phase, M2 and APU clock outputs of the master-clock divider, grouped for the pads logic.
// The master drives every signal and the pads logic only observes them.
interface apu_clk_div_if #(
  parameter int DIV = 12
);
  localparam int CW = $clog2(DIV);

  logic          PHI0;
  logic          PHI1;
  logic          PHI2;
  logic          n_M2_topad;
  logic          ACLK;
  logic          n_ACLK;
  logic          CPU_CYCLE;
  logic [CW-1:0] PHASE;

  modport master (
    output PHI0, PHI1, PHI2, n_M2_topad, ACLK, n_ACLK, CPU_CYCLE, PHASE
  );

  modport slave (
    input PHI0, PHI1, PHI2, n_M2_topad, ACLK, n_ACLK, CPU_CYCLE, PHASE
  );
endinterface

// File: rtl/apu_clk_div.sv
// Master-clock divider: 6502 phases, M2 drive, ACLK and per-cycle strobe from the CLK pad.
// Every output is a flop loaded from the decode of the next count, so it lines up with PHASE; free-running, no backpressure.
module apu_clk_div #(
  parameter int DIV      = 12,
  parameter int M2_START = 5
) (
  input  logic          CLK,
  input  logic          n_RES,
  apu_clk_div_if.master bus
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF    = CW'(DIV / 2);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] HALF_P1 = CW'(DIV / 2 + 1);
  localparam logic [CW-1:0] M2_AT   = CW'(M2_START);
  localparam logic [CW-1:0] ONE     = CW'(1);

  generate
    if ((DIV % 2) != 0 || DIV < 4) begin : g_bad_div
      $error("apu_clk_div: DIV must be even and at least 4");
    end
    if (M2_START < 1 || M2_START > DIV - 1) begin : g_bad_m2
      $error("apu_clk_div: M2_START must lie in 1..DIV-1");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d, nxt;
  logic          phi0_q, phi0_d;
  logic          phi1_q, phi1_d;
  logic          phi2_q, phi2_d;
  logic          n_m2_q, n_m2_d;
  logic          aclk_q, aclk_d;
  logic          n_aclk_q, n_aclk_d;
  logic          cpu_cycle_q, cpu_cycle_d;

  // Decoding nxt rather than cnt_q keeps each output aligned with the count it describes.
  always_comb begin
    nxt         = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    cnt_d       = nxt;
    phi0_d      = (nxt >= HALF);
    phi1_d      = (nxt >= ONE) && (nxt <= HALF_M1);
    phi2_d      = (nxt >= HALF_P1);
    n_m2_d      = !(nxt >= M2_AT);
    cpu_cycle_d = (nxt == LAST);
    aclk_d      = aclk_q ^ (nxt == '0);
    n_aclk_d    = ~aclk_d;
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      cnt_q       <= '0;
      phi0_q      <= 1'b0;
      phi1_q      <= 1'b0;
      phi2_q      <= 1'b0;
      n_m2_q      <= 1'b1;
      aclk_q      <= 1'b0;
      n_aclk_q    <= 1'b1;
      cpu_cycle_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phi0_q      <= phi0_d;
      phi1_q      <= phi1_d;
      phi2_q      <= phi2_d;
      n_m2_q      <= n_m2_d;
      aclk_q      <= aclk_d;
      n_aclk_q    <= n_aclk_d;
      cpu_cycle_q <= cpu_cycle_d;
    end
  end

  assign bus.PHASE      = cnt_q;
  assign bus.PHI0       = phi0_q;
  assign bus.PHI1       = phi1_q;
  assign bus.PHI2       = phi2_q;
  assign bus.n_M2_topad = n_m2_q;
  assign bus.ACLK       = aclk_q;
  assign bus.n_ACLK     = n_aclk_q;
  assign bus.CPU_CYCLE  = cpu_cycle_q;
endmodule

// File: tb/tb_apu_clk_div.sv
// Directed bench for apu_clk_div: default divider plus DIV=4/M2_START=1 and DIV=16/M2_START=10 variants.
module tb_apu_clk_div;
  logic CLK;
  logic n_RES;
  int   n_checks = 0;
  int   n_errors = 0;

  apu_clk_div_if #(.DIV(12)) ifa ();
  apu_clk_div_if #(.DIV(4))  ifb ();
  apu_clk_div_if #(.DIV(16)) ifc ();

  apu_clk_div #(.DIV(12), .M2_START(5))  u_dut_a (.CLK(CLK), .n_RES(n_RES), .bus(ifa));
  apu_clk_div #(.DIV(4),  .M2_START(1))  u_dut_b (.CLK(CLK), .n_RES(n_RES), .bus(ifb));
  apu_clk_div #(.DIV(16), .M2_START(10)) u_dut_c (.CLK(CLK), .n_RES(n_RES), .bus(ifc));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference counters and ACLK state for each divider.
  int mc_a, mc_b, mc_c;
  bit ma_a, ma_b, ma_c;

  function automatic int step(input int c, input int div);
    step = (c == div - 1) ? 0 : c + 1;
  endfunction

  always @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      mc_a <= 0; mc_b <= 0; mc_c <= 0;
      ma_a <= 1'b0; ma_b <= 1'b0; ma_c <= 1'b0;
    end else begin
      mc_a <= step(mc_a, 12);
      mc_b <= step(mc_b, 4);
      mc_c <= step(mc_c, 16);
      if (step(mc_a, 12) == 0) ma_a <= ~ma_a;
      if (step(mc_b, 4) == 0)  ma_b <= ~ma_b;
      if (step(mc_c, 16) == 0) ma_c <= ~ma_c;
    end
  end

  // Hand tables for the default divider, bit n = value at count n.
  logic [11:0] t_phi0, t_phi1, t_phi2, t_m2, t_cpu;

  // {PHI0, PHI1, PHI2, n_M2_topad, ACLK, n_ACLK, CPU_CYCLE} from the decode formulas.
  function automatic logic [6:0] exp_dec(input int div, input int m2s, input int c, input bit a);
    exp_dec = {c >= div / 2, (c >= 1) && (c <= div / 2 - 1), c >= div / 2 + 1,
               !(c >= m2s), a, !a, c == div - 1};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pack_a();
    pack_a = {ifa.PHI0, ifa.PHI1, ifa.PHI2, ifa.n_M2_topad, ifa.ACLK, ifa.n_ACLK, ifa.CPU_CYCLE};
  endfunction
  function automatic logic [6:0] pack_b();
    pack_b = {ifb.PHI0, ifb.PHI1, ifb.PHI2, ifb.n_M2_topad, ifb.ACLK, ifb.n_ACLK, ifb.CPU_CYCLE};
  endfunction
  function automatic logic [6:0] pack_c();
    pack_c = {ifc.PHI0, ifc.PHI1, ifc.PHI2, ifc.n_M2_topad, ifc.ACLK, ifc.n_ACLK, ifc.CPU_CYCLE};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, " a.phase"}, 32'(ifa.PHASE), 0);
    check({tag, " a.outs"},  32'(pack_a()),  32'(7'b0001010));
    check({tag, " b.phase"}, 32'(ifb.PHASE), 0);
    check({tag, " b.outs"},  32'(pack_b()),  32'(7'b0001010));
    check({tag, " c.phase"}, 32'(ifc.PHASE), 0);
    check({tag, " c.outs"},  32'(pack_c()),  32'(7'b0001010));
  endtask

  task automatic check_all(input string tag);
    logic [6:0] ea;
    ea = {t_phi0[mc_a], t_phi1[mc_a], t_phi2[mc_a], ~t_m2[mc_a], ma_a, ~ma_a, t_cpu[mc_a]};
    check({tag, " a.phase"}, 32'(ifa.PHASE), mc_a);
    check({tag, " a.outs"},  32'(pack_a()),  32'(ea));
    check({tag, " b.phase"}, 32'(ifb.PHASE), mc_b);
    check({tag, " b.outs"},  32'(pack_b()),  32'(exp_dec(4, 1, mc_b, ma_b)));
    check({tag, " c.phase"}, 32'(ifc.PHASE), mc_c);
    check({tag, " c.outs"},  32'(pack_c()),  32'(exp_dec(16, 10, mc_c, ma_c)));
  endtask

  initial begin
    int ncpu, ovl, m2a, phi0a, m2b, m2c, last_rise, k;
    bit prev_aclk;

    t_phi0 = 12'b1111_1100_0000;
    t_phi1 = 12'b0000_0011_1110;
    t_phi2 = 12'b1111_1000_0000;
    t_m2   = 12'b1111_1110_0000;
    t_cpu  = 12'b1000_0000_0000;

    n_RES = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      check_reset("reset_hold");
    end
    n_RES = 1'b1;
    @(negedge CLK);
    check("release_phase", 32'(ifa.PHASE), 1);
    check("release_phi1", 32'(ifa.PHI1), 1);
    check_all("release");

    ncpu = 0;
    repeat (48) begin
      @(negedge CLK);
      check_all("steady");
      if (ifa.CPU_CYCLE) begin
        ncpu++;
        check("cpu_cycle_phase", 32'(ifa.PHASE), 11);
      end
    end
    check("cpu_cycle_count", ncpu, 4);

    ovl = 0; m2a = 0; phi0a = 0; m2b = 0; m2c = 0;
    last_rise = -1;
    prev_aclk = ifa.ACLK;
    for (int i = 0; i < 240; i++) begin
      @(negedge CLK);
      check_all("window");
      ovl   += int'(ifa.PHI1 & ifa.PHI2) + int'(ifb.PHI1 & ifb.PHI2) + int'(ifc.PHI1 & ifc.PHI2);
      m2a   += int'(!ifa.n_M2_topad);
      phi0a += int'(ifa.PHI0);
      m2b   += int'(!ifb.n_M2_topad);
      m2c   += int'(!ifc.n_M2_topad);
      if (ifa.ACLK != prev_aclk) check("aclk_toggle_phase", 32'(ifa.PHASE), 0);
      if (ifa.ACLK && !prev_aclk) begin
        if (last_rise >= 0) check("aclk_period", i - last_rise, 24);
        last_rise = i;
      end
      prev_aclk = ifa.ACLK;
    end
    check("phi_overlap", ovl, 0);
    check("m2_high_a", m2a, 140);
    check("phi0_high_a", phi0a, 120);
    check("m2_high_b", m2b, 180);
    check("m2_high_c", m2c, 90);

    k = 0;
    while (mc_a != 8 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check("mid_wait_in_budget", 32'(k < 20), 1);
    check("mid_pre_phi2", 32'(ifa.PHI2), 1);
    check("mid_pre_n_m2", 32'(ifa.n_M2_topad), 0);
    #2 n_RES = 1'b0;
    #1;
    check("mid_phi2", 32'(ifa.PHI2), 0);
    check("mid_n_m2", 32'(ifa.n_M2_topad), 1);
    check("mid_phase", 32'(ifa.PHASE), 0);
    check_reset("mid_async");
    repeat (2) @(negedge CLK);
    check_reset("mid_hold");
    n_RES = 1'b1;
    @(negedge CLK);
    check("restart_phase", 32'(ifa.PHASE), 1);
    check("restart_phi1", 32'(ifa.PHI1), 1);
    repeat (30) begin
      @(negedge CLK);
      check_all("restart");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/apu_clk_div.md
# apu_clk_div

Master-clock divider for the APU, directly upstream of the pads logic. Takes the buffered master clock from the CLK pad and produces the 6502 core phases (PHI0/PHI1/PHI2), the APU half-rate clock (ACLK), a per-CPU-cycle strobe, and the active-low M2 drive (`n_M2_topad`) that the pads logic gates and drives onto the M2 pin. All outputs are registered, so there are no decode glitches on the phase lines.

## Interface
Parameters:
- `DIV`, 12, master clocks per CPU cycle; even, ≥ 4.
- `M2_START`, 5, counter value at which M2 goes high; legal range 1..DIV-1.

Ports:
- `CLK`  in  1  master clock from the CLK pad; only rising edges are used.
- `n_RES`  in  1  asynchronous, active-low reset.
- `PHI0`  out  1  CPU reference phase; high for the second half of the CPU cycle.
- `PHI1`  out  1  first-half phase; non-overlapping with `PHI2`.
- `PHI2`  out  1  second-half phase; non-overlapping with `PHI1`.
- `n_M2_topad`  out  1  active-low M2 drive to the pads logic.
- `ACLK`  out  1  APU clock; toggles once per CPU cycle.
- `n_ACLK`  out  1  complement of `ACLK`, driven from its own flop.
- `CPU_CYCLE`  out  1  one-`CLK` strobe in the last master clock of each CPU cycle.
- `PHASE`  out  $clog2(DIV)  current divider count, for debug and for the bench.

## Operation
- Phase counter `cnt` counts 0..DIV-1.
  - Increments on every rising edge of `CLK`.
  - Wraps from DIV-1 to 0.
  - Free-running: no enable and no synchronous clear.
- Define `nxt` = (cnt == DIV-1) ? 0 : cnt+1.
- On every edge, `cnt` ← `nxt`, and each output flop loads its decode of `nxt`:
  - `PHI0` = 1 when nxt ≥ DIV/2.
  - `PHI1` = 1 when 1 ≤ nxt ≤ DIV/2-1.
  - `PHI2` = 1 when nxt ≥ DIV/2+1.
  - `n_M2_topad` = 0 when nxt ≥ M2_START, otherwise 1.
  - `CPU_CYCLE` = 1 when nxt == DIV-1.
  - `ACLK` toggles when nxt == 0. `n_ACLK` loads the inverse of the new `ACLK` value.
- `PHASE` = `cnt`.
- Consequences of the decode:
  - `PHI1` and `PHI2` are never both 1.
  - At `cnt` 0 and `cnt` DIV/2 both phases are 0, giving a one-master-clock dead band.
  - M2 (the inverse of `n_M2_topad`) is high for DIV-M2_START clocks per CPU cycle: 7 of 12 with defaults.
- Illegal parameter values (odd `DIV`, `DIV` < 4, `M2_START` out of range) stop elaboration with an error.

## Timing
- Reset (`n_RES` = 0) takes effect immediately, independent of `CLK`. While held, outputs are:
  - `cnt` = 0, `PHASE` = 0
  - `PHI0` = `PHI1` = `PHI2` = 0
  - `n_M2_topad` = 1
  - `ACLK` = 0, `n_ACLK` = 1
  - `CPU_CYCLE` = 0
- Reset release: the first rising edge after `n_RES` rises gives `cnt` = 1 and `PHI1` = 1. A full CPU cycle then runs from the next wrap.
- Reset asserted mid-cycle: all state clears at once. No partial phase is completed; the divider restarts from 0.
- Output latency: each output reflects the count it decodes in the same cycle. Outputs change only on rising edges of `CLK`.
- Default sequence over `cnt` 0..11:
  - `PHI1` high at 1–5.
  - `PHI0` high at 6–11.
  - `PHI2` high at 7–11.
  - M2 high at 5–11.
  - `CPU_CYCLE` at 11.
  - `ACLK` flips entering `cnt` 0.
- `ACLK` period is 2·DIV master clocks (24 with defaults), 50 % duty.
- The pads logic owns tristating and the DBG/RES gating of M2; this block always drives `n_M2_topad`.

## Test plan
- Reset hold: `n_RES` = 0 for 5 clocks, then released → all outputs hold their reset values during reset; at the first edge after release `PHASE` = 1 and `PHI1` = 1.
- Steady state with defaults over 48 clocks → every 12-clock window matches the sequence in Timing; `CPU_CYCLE` asserts exactly 4 times, each time with `PHASE` = 11.
- Non-overlap and M2 duty → over 240 clocks, `PHI1` & `PHI2` is never 1; M2 high count = 140; `PHI0` high count = 120.
- ACLK → toggles at every entry to `PHASE` 0; period 24 clocks; `n_ACLK` == ~`ACLK` on every cycle after reset.
- Mid-cycle reset: assert `n_RES` = 0 asynchronously at `PHASE` = 8 (`PHI2` = 1, M2 high) → immediately `PHI2` = 0, `n_M2_topad` = 1, `PHASE` = 0; after release the sequence restarts at `PHASE` 1.
- Parameter sweep: `DIV` = 4 with `M2_START` = 1, and `DIV` = 16 with `M2_START` = 10 → decode matches the Operation formulas for every `PHASE`; M2 high 3/4 and 6/16 respectively.
